subbytes_shiftrows: RTL and testbench

//  Iterative AES SubBytes+ShiftRows stage (InvSubBytes+InvShiftRows when decrypting).

---
 rtl/subbytes_shiftrows.sv | 170 +++++++++++++++++
 tb/tb_subbytes_shiftrows.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_shiftrows.sv
// AES SubBytes+ShiftRows (or InvSubBytes+InvShiftRows) iterative round stage.
// BPC bytes are substituted per clock; the result register only updates once
// the whole 16-byte state has been processed.

// Shared FIPS-197 S-box tables; element x of each table is the image of x.
package aes_sbox_pkg;

  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[x];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[x];
  endfunction

endpackage

module subbytes_shiftrows #(
  parameter int unsigned BPC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         decrypt_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  import aes_sbox_pkg::*;

  localparam int unsigned N  = 16 / BPC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Byte k of the state sits in element ~k (byte 0 is the most significant).
  typedef logic [15:0][7:0] state_t;

  typedef enum logic {
    IDLE,
    BUSY
  } fsm_t;

  fsm_t          state_q, state_d;
  state_t        src_q, src_d;
  state_t        dst_q, dst_d;
  state_t        data_q, data_d;
  state_t        dst_upd;
  logic          mode_q, mode_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    k;
  logic [1:0]    row, col, dcol;
  logic [7:0]    sub;

  // Substitute the current chunk and scatter each byte to its row-shifted slot.
  always_comb begin
    dst_upd = dst_q;
    k       = '0;
    row     = '0;
    col     = '0;
    dcol    = '0;
    sub     = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      k    = 4'(cnt_q * BPC + i);
      row  = k[1:0];
      col  = k[3:2];
      // 2-bit arithmetic gives the mod-4 column wrap for free.
      dcol = mode_q ? (col + row) : (col - row);
      sub  = mode_q ? sbox_inv(src_q[~k]) : sbox_fwd(src_q[~k]);
      dst_upd[~{dcol, row}] = sub;
    end
  end

  // Next-state logic for the IDLE/BUSY controller and datapath registers.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    data_d  = data_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = data_i;
          mode_d  = decrypt_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dst_d = dst_upd;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          data_d  = dst_upd;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_subbytes_shiftrows.sv
// Randomised self-checking bench for subbytes_shiftrows at BPC = 1, 4 and 16.
// The reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_subbytes_shiftrows;

  logic         clk = 1'b0;
  logic         reset;
  logic         decrypt_i;
  logic [127:0] data_i;
  logic [2:0]   start_v;
  logic         rdy0, rdy1, rdy2;
  logic [127:0] dout0, dout1, dout2;
  logic [2:0]   rdy_v;
  logic [127:0] dout [3];

  int n_tests = 0;
  int n_fail  = 0;
  int pulses [3];

  logic [7:0] s_ref  [256];
  logic [7:0] si_ref [256];

  localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  subbytes_shiftrows #(.BPC(1)) u_b1 (
    .clk(clk), .reset(reset), .decrypt_i(decrypt_i), .start_i(start_v[0]),
    .data_i(data_i), .ready_o(rdy0), .data_o(dout0)
  );
  subbytes_shiftrows #(.BPC(4)) u_b4 (
    .clk(clk), .reset(reset), .decrypt_i(decrypt_i), .start_i(start_v[1]),
    .data_i(data_i), .ready_o(rdy1), .data_o(dout1)
  );
  subbytes_shiftrows #(.BPC(16)) u_b16 (
    .clk(clk), .reset(reset), .decrypt_i(decrypt_i), .start_i(start_v[2]),
    .data_i(data_i), .ready_o(rdy2), .data_o(dout2)
  );

  assign rdy_v   = {rdy2, rdy1, rdy0};
  assign dout[0] = dout0;
  assign dout[1] = dout1;
  assign dout[2] = dout2;

  initial pulses = '{0, 0, 0};
  always @(posedge rdy0) pulses[0]++;
  always @(posedge rdy1) pulses[1]++;
  always @(posedge rdy2) pulses[2]++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // out[r][c] = S(in[r][c+r]) forward, Sinv(in[r][c-r]) inverse (mod 4 on columns).
  function automatic logic [127:0] ref_model(input logic [127:0] din, input logic dec);
    logic [127:0] out = '0;
    logic [7:0]   b;
    int           src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = dec ? (4 * ((c + 4 - r) % 4) + r) : (4 * ((c + r) % 4) + r);
        b   = 8'(din >> (8 * (15 - src)));
        out = {out[119:0], (dec ? si_ref[b] : s_ref[b])};
      end
    end
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lat_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 17;
      2'd1:    return 5;
      default: return 2;
    endcase
  endfunction

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic issue(input logic [1:0] idx, input logic [127:0] din, input logic dec);
    data_i       = din;
    decrypt_i    = dec;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic await_done(input logic [1:0] idx, input logic noisy, output int cyc);
    cyc = 1;
    while (!rdy_v[idx] && cyc < 64) begin
      if (noisy) begin
        start_v[idx] = 1'($urandom);
        data_i       = rand128();
        decrypt_i    = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start_v[idx] = 1'b0;
  endtask

  task automatic run_block(input logic [1:0] idx, input logic [127:0] din, input logic dec,
                           input logic noisy, input logic [127:0] exp, input string tag);
    int cyc;
    issue(idx, din, dec);
    await_done(idx, noisy, cyc);
    chk({tag, " ready"}, 128'(rdy_v[idx]), 128'd1);
    chk({tag, " data"}, dout[idx], exp);
    chk({tag, " latency"}, 128'(cyc), 128'(lat_of(idx)));
  endtask

  initial begin
    logic [1:0]   idx;
    logic [127:0] din;
    logic         dec;
    int           p;
    string        nm;

    for (int x = 0; x < 256; x++) s_ref[x] = sbox_model(8'(x));
    for (int x = 0; x < 256; x++) si_ref[s_ref[x]] = 8'(x);

    reset     = 1'b0;
    start_v   = 3'b111;
    data_i    = rand128();
    decrypt_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      idx = 2'(i);
      chk($sformatf("reset ready b%0d", i), 128'(rdy_v[idx]), 128'd0);
      chk($sformatf("reset data b%0d", i), dout[idx], 128'd0);
    end
    start_v = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("idle no pulse b%0d", i), 128'(pulses[i]), 128'd0);

    for (int i = 0; i < 3; i++) begin
      idx = 2'(i);
      nm  = $sformatf("b%0d", i);

      run_block(idx, VEC_IN, 1'b0, 1'b0, VEC_OUT, {nm, " fips fwd"});
      run_block(idx, VEC_OUT, 1'b1, 1'b0, VEC_IN, {nm, " fips inv"});
      run_block(idx, '0, 1'b0, 1'b0, {16{8'h63}}, {nm, " zero fwd"});
      run_block(idx, {16{8'h63}}, 1'b1, 1'b0, '0, {nm, " const inv"});

      for (int t = 0; t < 6; t++) begin
        din = rand128();
        dec = 1'($urandom);
        run_block(idx, din, dec, 1'b0, ref_model(din, dec), $sformatf("%s rand%0d", nm, t));
      end
      repeat (3) @(negedge clk);
      chk({nm, " hold"}, dout[idx], ref_model(din, dec));

      p = pulses[idx];
      run_block(idx, VEC_IN, 1'b0, 1'b1, VEC_OUT, {nm, " noisy"});
      run_block(idx, VEC_OUT, 1'b1, 1'b0, VEC_IN, {nm, " back2back"});
      chk({nm, " pulse count"}, 128'(pulses[idx] - p), 128'd2);

      p = pulses[idx];
      issue(idx, rand128(), 1'($urandom));
      if (lat_of(idx) > 2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk({nm, " abort ready"}, 128'(rdy_v[idx]), 128'd0);
      chk({nm, " abort data"}, dout[idx], 128'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (lat_of(idx) + 2) @(negedge clk);
      chk({nm, " abort no pulse"}, 128'(pulses[idx] - p), 128'd0);
      din = rand128();
      dec = 1'($urandom);
      run_block(idx, din, dec, 1'b0, ref_model(din, dec), {nm, " after abort"});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
